// File: rtl/pong_game_controller.sv
// Pong match controller: serve/play/point/game-over sequencing and score keeping.
// Optional feature macro: PONG_AUTO_SERVE_EN -- SERVE also launches the ball on the
// frame_tick that brings the frame counter to SERVE_FRAMES.
// Ports:
//   clk, reset_n            pixel clock, asynchronous active-low reset
//   endofframe              frame-end level from VGA timing (synchronous to clk)
//   serve_btn               raw asynchronous serve button, active-high
//   ball_x, ball_y          ball top-left position
//   ball_hold, ball_run     ball control (registered)
//   serve_dir               initial ball direction, 0 = left, 1 = right
//   score_l, score_r        player scores
//   game_over, winner       match decided flag and winning side (1 = right)
//   state                   current FSM state code
module pong_game_controller #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned LEFT_GOAL    = 30,
  parameter int unsigned RIGHT_GOAL   = 600,
  parameter int unsigned BALL_SIZE    = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       endofframe,
  input  logic       serve_btn,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       ball_hold,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned EDGE_W  = 11;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_d, score_r_d, new_score;
  logic               dir_d, over_d, winner_d, hold_d, run_d;
  logic               btn_s1, btn_s2, btn_s3, armed_q, serve_press;
  logic [1:0]         settle_q;
  logic               eof_q, frame_tick;
  logic [EDGE_W-1:0]  right_edge;
  logic               goal_left, goal_right;

  // Vertical position is not used by the goal logic.
  logic unused_ball_y;
  assign unused_ball_y = ^ball_y;

  assign frame_tick = endofframe & ~eof_q;
  assign right_edge = EDGE_W'(ball_x) + EDGE_W'(BALL_SIZE) - EDGE_W'(1);
  assign goal_left  = EDGE_W'(ball_x) <= EDGE_W'(LEFT_GOAL);
  assign goal_right = right_edge >= EDGE_W'(RIGHT_GOAL);
  assign state      = state_q;

  // Button synchronizer and edge detector. The detector only arms once the
  // synchronized button has been seen low after reset, so a button held through
  // reset release cannot produce a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_s3      <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      serve_press <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      btn_s1      <= serve_btn;
      btn_s2      <= btn_s1;
      btn_s3      <= btn_s2;
      eof_q       <= endofframe;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if ((settle_q == 2'd2) && !btn_s2) armed_q <= 1'b1;
      serve_press <= armed_q & btn_s2 & ~btn_s3;
    end
  end

  // Next state and next register values; winner doubles as the last scorer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l;
    score_r_d = score_r;
    dir_d     = serve_dir;
    over_d    = game_over;
    winner_d  = winner;
    new_score = '0;
    case (state_q)
      IDLE: begin
        if (serve_press) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (frame_tick) cnt_d = cnt_q + CNT_W'(1);
        if (serve_press) begin
          state_d = PLAY;
        end
`ifdef PONG_AUTO_SERVE_EN
        else if (frame_tick && ((cnt_q + CNT_W'(1)) == CNT_W'(SERVE_FRAMES))) begin
          state_d = PLAY;
        end
`endif
      end
      PLAY: begin
        if (frame_tick && goal_left) begin
          state_d  = POINT;
          winner_d = 1'b1;
        end else if (frame_tick && goal_right) begin
          state_d  = POINT;
          winner_d = 1'b0;
        end
      end
      POINT: begin
        cnt_d = '0;
        if (winner) begin
          new_score = (score_r == SCORE_MAX) ? SCORE_MAX : score_r + SCORE_W'(1);
          score_r_d = new_score;
          dir_d     = 1'b0;
        end else begin
          new_score = (score_l == SCORE_MAX) ? SCORE_MAX : score_l + SCORE_W'(1);
          score_l_d = new_score;
          dir_d     = 1'b1;
        end
        if (new_score == SCORE_W'(WIN_SCORE)) begin
          state_d = OVER;
          over_d  = 1'b1;
        end else begin
          state_d = SERVE;
        end
      end
      OVER: begin
        if (serve_press) begin
          state_d   = SERVE;
          score_l_d = '0;
          score_r_d = '0;
          over_d    = 1'b0;
          cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    hold_d = (state_d != PLAY);
    run_d  = (state_d == PLAY);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      score_l   <= '0;
      score_r   <= '0;
      serve_dir <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
      ball_hold <= 1'b1;
      ball_run  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      serve_dir <= dir_d;
      game_over <= over_d;
      winner    <= winner_d;
      ball_hold <= hold_d;
      ball_run  <= run_d;
    end
  end

endmodule
